dport_arbiter: RTL and testbench

Two-requester arbiter sharing the single hart data port between the load/store queue (requester 0) and a secondary master (requester 1, e.g. debug/DMA). It grants requests round-robin, holds a grant until the memory side accepts it, and records the requester ID of every issued request in an in-order ID queue. Responses are routed back by the head of that queue. It sits between the lsqueue data port and the external data bus.

---
 rtl/dport_arbiter.sv | 125 ++++++++++++
 tb/tb_dport_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dport_arbiter.sv
// Round-robin arbiter sharing the hart data port between the LSQ (r0) and a secondary master (r1).
// An in-order ID queue records the issuer of every request and steers each response back to it.
module dport_arbiter #(
  parameter int XLEN           = 32,
  parameter int C_OSTD_DEPTH_X = 2
) (
  input  logic            clk_i,
  input  logic            resetb_i,
  input  logic            clk_en_i,
  // requester 0
  output logic            r0_reqready_o,
  input  logic            r0_reqvalid_i,
  input  logic            r0_reqdvalid_i,
  input  logic [1:0]      r0_reqhpl_i,
  input  logic [XLEN-1:0] r0_reqaddr_i,
  input  logic [XLEN-1:0] r0_reqdata_i,
  input  logic            r0_rspready_i,
  output logic            r0_rspvalid_o,
  output logic            r0_rsprerr_o,
  output logic            r0_rspwerr_o,
  output logic [XLEN-1:0] r0_rspdata_o,
  // requester 1
  output logic            r1_reqready_o,
  input  logic            r1_reqvalid_i,
  input  logic            r1_reqdvalid_i,
  input  logic [1:0]      r1_reqhpl_i,
  input  logic [XLEN-1:0] r1_reqaddr_i,
  input  logic [XLEN-1:0] r1_reqdata_i,
  input  logic            r1_rspready_i,
  output logic            r1_rspvalid_o,
  output logic            r1_rsprerr_o,
  output logic            r1_rspwerr_o,
  output logic [XLEN-1:0] r1_rspdata_o,
  // external data bus
  input  logic            dreqready_i,
  output logic            dreqvalid_o,
  output logic            dreqdvalid_o,
  output logic [1:0]      dreqhpl_o,
  output logic [XLEN-1:0] dreqaddr_o,
  output logic [XLEN-1:0] dreqdata_o,
  output logic            drspready_o,
  input  logic            drspvalid_i,
  input  logic            drsprerr_i,
  input  logic            drspwerr_i,
  input  logic [XLEN-1:0] drspdata_i
);

  localparam int DEPTH = 2 ** C_OSTD_DEPTH_X;
  localparam logic [C_OSTD_DEPTH_X:0] DEPTH_C = (C_OSTD_DEPTH_X + 1)'(DEPTH);

  logic                      prio, lock, lock_id, sel;
  logic                      sel_reqvalid, idq_full, idq_empty, head;
  logic                      push, pop;
  logic [DEPTH-1:0]          idq_mem;
  logic [C_OSTD_DEPTH_X-1:0] wptr, rptr;
  logic [C_OSTD_DEPTH_X:0]   cnt;

  assign idq_full  = (cnt == DEPTH_C);
  assign idq_empty = (cnt == '0);
  assign head      = idq_mem[rptr];

  // A stalled grant stays locked so the pending payload cannot change under the bus.
  always_comb begin
    sel = 1'b0;
    if (lock)
      sel = lock_id;
    else if (r0_reqvalid_i && r1_reqvalid_i)
      sel = prio;
    else if (r1_reqvalid_i)
      sel = 1'b1;
  end

  assign sel_reqvalid  = sel ? r1_reqvalid_i : r0_reqvalid_i;
  assign dreqvalid_o   = sel_reqvalid & ~idq_full;
  assign dreqdvalid_o  = sel ? r1_reqdvalid_i : r0_reqdvalid_i;
  assign dreqhpl_o     = sel ? r1_reqhpl_i    : r0_reqhpl_i;
  assign dreqaddr_o    = sel ? r1_reqaddr_i   : r0_reqaddr_i;
  assign dreqdata_o    = sel ? r1_reqdata_i   : r0_reqdata_i;
  assign r0_reqready_o = ~sel & r0_reqvalid_i & dreqready_i & ~idq_full;
  assign r1_reqready_o =  sel & r1_reqvalid_i & dreqready_i & ~idq_full;

  assign drspready_o   = ~idq_empty & (head ? r1_rspready_i : r0_rspready_i);
  assign r0_rspvalid_o = drspvalid_i & ~idq_empty & ~head;
  assign r1_rspvalid_o = drspvalid_i & ~idq_empty &  head;
  assign r0_rsprerr_o  = drsprerr_i;
  assign r1_rsprerr_o  = drsprerr_i;
  assign r0_rspwerr_o  = drspwerr_i;
  assign r1_rspwerr_o  = drspwerr_i;
  assign r0_rspdata_o  = drspdata_i;
  assign r1_rspdata_o  = drspdata_i;

  assign push = clk_en_i & dreqvalid_o & dreqready_i;
  assign pop  = clk_en_i & drspvalid_i & drspready_o;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      prio    <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
    end else if (clk_en_i) begin
      if (push) begin
        prio <= ~sel;
        lock <= 1'b0;
      end else if (dreqvalid_o && !dreqready_i) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      cnt <= cnt + (C_OSTD_DEPTH_X + 1)'(push) - (C_OSTD_DEPTH_X + 1)'(pop);
    end
  end

  // Queue storage holds only requester IDs; validity comes from cnt, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push)
      idq_mem[wptr] <= sel;
  end

endmodule

// File: tb/tb_dport_arbiter.sv
// Directed bench for dport_arbiter: grant order, locking, ID-queue full/empty and response routing.
module tb_dport_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic resetb, clk_en;
  logic r0_reqready, r0_reqvalid, r0_reqdvalid, r0_rspready, r0_rspvalid, r0_rsprerr, r0_rspwerr;
  logic r1_reqready, r1_reqvalid, r1_reqdvalid, r1_rspready, r1_rspvalid, r1_rsprerr, r1_rspwerr;
  logic [1:0] r0_reqhpl, r1_reqhpl, dreqhpl;
  logic [XLEN-1:0] r0_reqaddr, r0_reqdata, r0_rspdata, r1_reqaddr, r1_reqdata, r1_rspdata;
  logic dreqready, dreqvalid, dreqdvalid, drspready, drspvalid, drsprerr, drspwerr;
  logic [XLEN-1:0] dreqaddr, dreqdata, drspdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dport_arbiter #(.XLEN(XLEN), .C_OSTD_DEPTH_X(2)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .r0_reqready_o(r0_reqready), .r0_reqvalid_i(r0_reqvalid), .r0_reqdvalid_i(r0_reqdvalid),
    .r0_reqhpl_i(r0_reqhpl), .r0_reqaddr_i(r0_reqaddr), .r0_reqdata_i(r0_reqdata),
    .r0_rspready_i(r0_rspready), .r0_rspvalid_o(r0_rspvalid), .r0_rsprerr_o(r0_rsprerr),
    .r0_rspwerr_o(r0_rspwerr), .r0_rspdata_o(r0_rspdata),
    .r1_reqready_o(r1_reqready), .r1_reqvalid_i(r1_reqvalid), .r1_reqdvalid_i(r1_reqdvalid),
    .r1_reqhpl_i(r1_reqhpl), .r1_reqaddr_i(r1_reqaddr), .r1_reqdata_i(r1_reqdata),
    .r1_rspready_i(r1_rspready), .r1_rspvalid_o(r1_rspvalid), .r1_rsprerr_o(r1_rsprerr),
    .r1_rspwerr_o(r1_rspwerr), .r1_rspdata_o(r1_rspdata),
    .dreqready_i(dreqready), .dreqvalid_o(dreqvalid), .dreqdvalid_o(dreqdvalid),
    .dreqhpl_o(dreqhpl), .dreqaddr_o(dreqaddr), .dreqdata_o(dreqdata),
    .drspready_o(drspready), .drspvalid_i(drspvalid), .drsprerr_i(drsprerr),
    .drspwerr_i(drspwerr), .drspdata_i(drspdata)
  );

  task automatic idle_inputs();
    clk_en = 1'b1;
    r0_reqvalid = 0; r0_reqdvalid = 0; r0_reqhpl = 2'd0; r0_reqaddr = 32'h200; r0_reqdata = 32'h0;
    r1_reqvalid = 0; r1_reqdvalid = 0; r1_reqhpl = 2'd3; r1_reqaddr = 32'h300; r1_reqdata = 32'h0;
    r0_rspready = 1; r1_rspready = 1; dreqready = 1;
    drspvalid = 0; drsprerr = 0; drspwerr = 0; drspdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    tick();
    resetb = 1'b0;
    idle_inputs();
    #2 resetb = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    idle_inputs();
    #2;
    checks++; if ({dreqvalid, r0_reqready, r1_reqready} !== 3'b000) begin
      errors++; $display("FAIL reset_req got %b exp 000", {dreqvalid, r0_reqready, r1_reqready}); end
    drspvalid = 1;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_empty_rsp got %b exp 000", {drspready, r0_rspvalid, r1_rspvalid}); end
    drspvalid = 0;
    #2 resetb = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    apply_reset();
    r0_reqvalid = 1; r0_reqdvalid = 1; r0_reqaddr = 32'h100; r0_reqdata = 32'hDEADBEEF;
    #1;
    checks++; if ({dreqvalid, dreqdvalid, r0_reqready, r1_reqready} !== 4'b1110) begin
      errors++; $display("FAIL store_hs got %b exp 1110", {dreqvalid, dreqdvalid, r0_reqready, r1_reqready}); end
    checks++; if (dreqaddr !== 32'h100 || dreqdata !== 32'hDEADBEEF || dreqhpl !== 2'd0) begin
      errors++; $display("FAIL store_payload got %h/%h/%0d exp 100/deadbeef/0", dreqaddr, dreqdata, dreqhpl); end
    tick();
    idle_inputs(); drspvalid = 1; drspdata = 32'h11;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid} !== 3'b110 || r0_rspdata !== 32'h11) begin
      errors++; $display("FAIL store_rsp got %b %h exp 110 11", {drspready, r0_rspvalid, r1_rspvalid}, r0_rspdata); end
    tick();
    #1;
    checks++; if ({drspready, r0_rspvalid} !== 2'b00) begin
      errors++; $display("FAIL store_drained got %b exp 00", {drspready, r0_rspvalid}); end
    idle_inputs();
  endtask

  task automatic test_alternate();
    logic [5:0] exp_g;
    exp_g = 6'b101010;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      r0_reqvalid = 1; r1_reqvalid = 1; drspvalid = (k > 0);
      #1;
      checks++; if ({r1_reqready, r0_reqready} !== (exp_g[k] ? 2'b10 : 2'b01) ||
                    dreqaddr !== (exp_g[k] ? 32'h300 : 32'h200)) begin
        errors++; $display("FAIL alt_grant%0d got rdy %b addr %h exp grant %0d", k, {r1_reqready, r0_reqready}, dreqaddr, exp_g[k]); end
      if (k > 0) begin
        checks++; if ({r1_rspvalid, r0_rspvalid} !== (exp_g[k-1] ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_rsp%0d got %b exp head %0d", k, {r1_rspvalid, r0_rspvalid}, exp_g[k-1]); end
      end
      tick();
    end
    r0_reqvalid = 0; r1_reqvalid = 0; drspvalid = 1;
    #1;
    checks++; if ({drspready, r1_rspvalid, r0_rspvalid} !== 3'b110) begin
      errors++; $display("FAIL alt_last_rsp got %b exp 110", {drspready, r1_rspvalid, r0_rspvalid}); end
    tick();
    #1;
    checks++; if (drspready !== 1'b0) begin
      errors++; $display("FAIL alt_drained got %b exp 0", drspready); end
    idle_inputs();
  endtask

  task automatic test_lock();
    apply_reset();
    dreqready = 0; r1_reqvalid = 1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) r0_reqvalid = 1;
      #1;
      checks++; if (dreqvalid !== 1'b1 || dreqaddr !== 32'h300 || dreqhpl !== 2'd3 || {r0_reqready, r1_reqready} !== 2'b00) begin
        errors++; $display("FAIL lock_hold%0d got v%b addr %h rdy %b exp v1 addr 300 rdy 00", k, dreqvalid, dreqaddr, {r0_reqready, r1_reqready}); end
      tick();
    end
    dreqready = 1;
    #1;
    checks++; if ({r1_reqready, r0_reqready} !== 2'b10 || dreqaddr !== 32'h300) begin
      errors++; $display("FAIL lock_release got %b %h exp 10 300", {r1_reqready, r0_reqready}, dreqaddr); end
    tick();
    #1;
    checks++; if ({r1_reqready, r0_reqready} !== 2'b01 || dreqaddr !== 32'h200) begin
      errors++; $display("FAIL lock_next got %b %h exp 01 200", {r1_reqready, r0_reqready}, dreqaddr); end
    tick();
    r0_reqvalid = 0; r1_reqvalid = 0; drspvalid = 1;
    #1;
    checks++; if ({r1_rspvalid, r0_rspvalid} !== 2'b10) begin
      errors++; $display("FAIL lock_rsp_r1 got %b exp 10", {r1_rspvalid, r0_rspvalid}); end
    tick();
    #1;
    checks++; if ({r1_rspvalid, r0_rspvalid} !== 2'b01) begin
      errors++; $display("FAIL lock_rsp_r0 got %b exp 01", {r1_rspvalid, r0_rspvalid}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    r0_reqvalid = 1;
    for (int k = 0; k < 4; k++) begin
      r0_reqaddr = 32'h10 * (k + 1);
      #1;
      checks++; if ({dreqvalid, r0_reqready} !== 2'b11) begin
        errors++; $display("FAIL full_fill%0d got %b exp 11", k, {dreqvalid, r0_reqready}); end
      tick();
    end
    r0_reqaddr = 32'h50;
    #1;
    checks++; if ({dreqvalid, r0_reqready} !== 2'b00) begin
      errors++; $display("FAIL full_block got %b exp 00", {dreqvalid, r0_reqready}); end
    drspvalid = 1; drspdata = 32'h55;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid, dreqvalid} !== 4'b1100 || r0_rspdata !== 32'h55) begin
      errors++; $display("FAIL full_pop got %b %h exp 1100 55", {drspready, r0_rspvalid, r1_rspvalid, dreqvalid}, r0_rspdata); end
    tick();
    drspvalid = 0;
    #1;
    checks++; if ({dreqvalid, r0_reqready} !== 2'b11 || dreqaddr !== 32'h50) begin
      errors++; $display("FAIL full_fifth got %b %h exp 11 50", {dreqvalid, r0_reqready}, dreqaddr); end
    tick();
    r0_reqvalid = 0; drspvalid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({drspready, r0_rspvalid} !== 2'b11) begin
        errors++; $display("FAIL full_drain%0d got %b exp 11", k, {drspready, r0_rspvalid}); end
      tick();
    end
    #1;
    checks++; if (drspready !== 1'b0) begin
      errors++; $display("FAIL full_empty got %b exp 0", drspready); end
    idle_inputs();
  endtask

  task automatic test_rsp_block();
    apply_reset();
    r0_reqvalid = 1; tick();
    r0_reqvalid = 0; r1_reqvalid = 1;
    #1;
    checks++; if (r1_reqready !== 1'b1) begin
      errors++; $display("FAIL blk_issue_r1 got %b exp 1", r1_reqready); end
    tick();
    r1_reqvalid = 0; r0_rspready = 0; drspvalid = 1; drspdata = 32'hA;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid} !== 3'b010) begin
      errors++; $display("FAIL blk_stall got %b exp 010", {drspready, r0_rspvalid, r1_rspvalid}); end
    tick();
    r0_rspready = 1;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid} !== 3'b110 || r0_rspdata !== 32'hA) begin
      errors++; $display("FAIL blk_r0 got %b %h exp 110 a", {drspready, r0_rspvalid, r1_rspvalid}, r0_rspdata); end
    tick();
    drspdata = 32'hB;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid} !== 3'b101 || r1_rspdata !== 32'hB) begin
      errors++; $display("FAIL blk_r1 got %b %h exp 101 b", {drspready, r0_rspvalid, r1_rspvalid}, r1_rspdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_clk_en();
    apply_reset();
    clk_en = 0; r0_reqvalid = 1;
    #1;
    checks++; if ({dreqvalid, r0_reqready} !== 2'b11) begin
      errors++; $display("FAIL cen_comb got %b exp 11", {dreqvalid, r0_reqready}); end
    tick();
    r0_reqvalid = 0; r1_reqvalid = 1; dreqready = 0; drspvalid = 1;
    #1;
    checks++; if (drspready !== 1'b0) begin
      errors++; $display("FAIL cen_nopush got %b exp 0", drspready); end
    tick();
    clk_en = 1; drspvalid = 0; dreqready = 1; r0_reqvalid = 1;
    #1;
    checks++; if ({r1_reqready, r0_reqready} !== 2'b01) begin
      errors++; $display("FAIL cen_nolock got %b exp 01", {r1_reqready, r0_reqready}); end
    tick();
    r0_reqvalid = 0; r1_reqvalid = 0; drspvalid = 1; tick();
    idle_inputs();
  endtask

  task automatic test_error_and_reset();
    apply_reset();
    r1_reqvalid = 1; tick();
    r1_reqvalid = 0; drspvalid = 1; drsprerr = 1; drspdata = 32'h2000;
    #1;
    checks++; if ({r1_rspvalid, r1_rsprerr, r0_rspvalid, drspready} !== 4'b1101 || r1_rspdata !== 32'h2000) begin
      errors++; $display("FAIL err_route got %b %h exp 1101 2000", {r1_rspvalid, r1_rsprerr, r0_rspvalid, drspready}, r1_rspdata); end
    tick();
    #1;
    checks++; if (drspready !== 1'b0) begin
      errors++; $display("FAIL err_popped got %b exp 0", drspready); end
    idle_inputs();
    r0_reqvalid = 1; tick(); tick();
    r0_reqvalid = 0; r1_reqvalid = 1; dreqready = 0; tick();
    resetb = 0;
    idle_inputs(); drspvalid = 1;
    #1;
    checks++; if ({dreqvalid, drspready, r0_rspvalid, r1_rspvalid} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid got %b exp 0000", {dreqvalid, drspready, r0_rspvalid, r1_rspvalid}); end
    #1 resetb = 1;
    tick();
    drspvalid = 0; r0_reqvalid = 1; r1_reqvalid = 1;
    #1;
    checks++; if ({r1_reqready, r0_reqready} !== 2'b01) begin
      errors++; $display("FAIL rst_prio got %b exp 01", {r1_reqready, r0_reqready}); end
    tick();
    r0_reqvalid = 0; r1_reqvalid = 0; drspvalid = 1;
    #1;
    checks++; if ({drspready, r0_rspvalid, r1_rspvalid} !== 3'b110) begin
      errors++; $display("FAIL rst_queue got %b exp 110", {drspready, r0_rspvalid, r1_rspvalid}); end
    tick();
    #1;
    checks++; if (drspready !== 1'b0) begin
      errors++; $display("FAIL rst_empty got %b exp 0", drspready); end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_store();
    test_alternate();
    test_lock();
    test_full();
    test_rsp_block();
    test_clk_en();
    test_error_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
